// File: rtl/li_rx_join_pkg.sv
// ---------------------------------------------------------------------------
// li_rx_join_pkg
// Shared helpers for the latency-insensitive receive-join slice.
//   tok_w(w) : physical width of a token bus whose logical width may be 0.
//              A 0-width data channel still needs a 1-bit port so the bus
//              shape stays uniform across configurations.
// ---------------------------------------------------------------------------
package li_rx_join_pkg;

    function automatic int tok_w(input int w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/li_rx_join_if.sv
// ---------------------------------------------------------------------------
// li_rx_join_if
// Bundles the two VALID/CONSUMED input channels, the joined output pair,
// the FIRE strobe and the stall counter of li_rx_join.
//   width : logical data token width (0 = no data channel)
//   cnt_w : stall counter width
// Modports:
//   slave  : the li_rx_join side (takes tokens, presents the pair)
//   master : the producer/consumer side driving tokens and FIRE
// ---------------------------------------------------------------------------
interface li_rx_join_if
    import li_rx_join_pkg::*;
#(
    parameter int width = 1,
    parameter int cnt_w = 16
);
    localparam int dw = tok_w(width);

    logic [dw-1:0]    IN_WRITE;
    logic             IN_WRITE_VALID;
    logic             IN_WRITE_CONSUMED;
    logic             IN_EN_WRITE;
    logic             IN_EN_WRITE_VALID;
    logic             IN_EN_WRITE_CONSUMED;
    logic [dw-1:0]    OUT_READ;
    logic             OUT_EN;
    logic             OUT_READY;
    logic             FIRE;
    logic [cnt_w-1:0] STALL_CNT;

    modport slave (
        input  IN_WRITE, IN_WRITE_VALID,
        output IN_WRITE_CONSUMED,
        input  IN_EN_WRITE, IN_EN_WRITE_VALID,
        output IN_EN_WRITE_CONSUMED,
        output OUT_READ, OUT_EN, OUT_READY,
        input  FIRE,
        output STALL_CNT
    );

    modport master (
        output IN_WRITE, IN_WRITE_VALID,
        input  IN_WRITE_CONSUMED,
        output IN_EN_WRITE, IN_EN_WRITE_VALID,
        input  IN_EN_WRITE_CONSUMED,
        input  OUT_READ, OUT_EN, OUT_READY,
        output FIRE,
        input  STALL_CNT
    );

endinterface

// File: rtl/li_rx_fifo.sv
// ---------------------------------------------------------------------------
// li_rx_fifo
// Per-channel token buffer: synchronous FIFO with a registered occupancy
// count. The producer handshake (in_consumed) is derived only from that
// registered count, so a full buffer cannot accept a token in the same
// cycle a dequeue frees a slot; the slot shows up one cycle later.
// Ports:
//   CLK, RST_N   : clock, synchronous active-low reset
//   in_data      : incoming token
//   in_valid     : token present
//   in_consumed  : token taken this cycle (1 when no token is offered)
//   deq          : pop the head at the edge (ignored when empty)
//   head         : current head token (don't-care when empty)
//   empty        : no tokens buffered
// ---------------------------------------------------------------------------
module li_rx_fifo #(
    parameter int width = 1,
    parameter int depth = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_consumed,
    input  logic             deq,
    output logic [width-1:0] head,
    output logic             empty
);
    localparam int             ptr_w    = $clog2(depth);
    localparam logic [ptr_w:0] full_cnt = (ptr_w + 1)'(depth);
    localparam logic [ptr_w-1:0] ptr_one = ptr_w'(1);
    localparam logic [ptr_w:0]   cnt_one = (ptr_w + 1)'(1);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w:0]   count;
    logic             full;
    logic             enq;
    logic             do_deq;

    assign full        = (count == full_cnt);
    assign empty       = (count == '0);
    assign enq         = in_valid && !full;
    assign do_deq      = deq && !empty;
    assign in_consumed = !in_valid || !full;
    assign head        = mem[rd_ptr];

    // Pointers wrap naturally at depth (power of two).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)    wr_ptr <= wr_ptr + ptr_one;
            if (do_deq) rd_ptr <= rd_ptr + ptr_one;
            case ({enq, do_deq})
                2'b10:   count <= count + cnt_one;
                2'b01:   count <= count - cnt_one;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers and the
    // count already discards every entry, and the head is don't-care when empty.
    always_ff @(posedge CLK) begin
        if (enq) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/li_rx_join.sv
// ---------------------------------------------------------------------------
// li_rx_join
// Receiving end of the VALID/CONSUMED token protocol. The data channel
// (WRITE) and the enable channel (EN_WRITE) are buffered independently and
// joined into one pair for a single-cycle consumer, which takes it with
// FIRE. FIRE while no pair is ready is counted in a saturating STALL_CNT.
// Parameters:
//   width : data token width, 0 removes the data channel
//   depth : entries per channel buffer (power of two, >= 2)
//   cnt_w : stall counter width
// Ports:
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : li_rx_join_if.slave (both input channels, joined output,
//                FIRE, STALL_CNT)
// ---------------------------------------------------------------------------
module li_rx_join
    import li_rx_join_pkg::*;
#(
    parameter int width = 1,
    parameter int depth = 2,
    parameter int cnt_w = 16
) (
    input logic         CLK,
    input logic         RST_N,
    li_rx_join_if.slave bus
);
    localparam int               dw      = tok_w(width);
    localparam logic [cnt_w-1:0] cnt_max = '1;
    localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

    logic             wr_empty;
    logic             en_empty;
    logic             en_head;
    logic             ready;
    logic             deq;
    logic [cnt_w-1:0] stall_cnt;
    logic [cnt_w-1:0] stall_nxt;

    // A pair exists only when both heads are present; both pop together.
    assign ready = !wr_empty && !en_empty;
    assign deq   = bus.FIRE && ready;

    li_rx_fifo #(
        .width(1),
        .depth(depth)
    ) u_en_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_data    (bus.IN_EN_WRITE),
        .in_valid   (bus.IN_EN_WRITE_VALID),
        .in_consumed(bus.IN_EN_WRITE_CONSUMED),
        .deq        (deq),
        .head       (en_head),
        .empty      (en_empty)
    );

    generate
        if (width != 0) begin : g_data
            logic [dw-1:0] wr_head;

            li_rx_fifo #(
                .width(dw),
                .depth(depth)
            ) u_wr_fifo (
                .CLK        (CLK),
                .RST_N      (RST_N),
                .in_data    (bus.IN_WRITE),
                .in_valid   (bus.IN_WRITE_VALID),
                .in_consumed(bus.IN_WRITE_CONSUMED),
                .deq        (deq),
                .head       (wr_head),
                .empty      (wr_empty)
            );

            assign bus.OUT_READ = wr_head;
        end else begin : g_no_data
            // Absent data channel: always accepts, never blocks the join.
            assign wr_empty              = 1'b0;
            assign bus.IN_WRITE_CONSUMED = 1'b1;
            assign bus.OUT_READ          = '0;
        end
    endgenerate

    assign bus.OUT_EN    = en_head;
    assign bus.OUT_READY = ready;
    assign bus.STALL_CNT = stall_cnt;

    // NOTE: the default assignment at the top of this block keeps stall_nxt
    // driven on every path, so no latch is inferred.
    always_comb begin
        stall_nxt = stall_cnt;
        if (bus.FIRE && !ready && (stall_cnt != cnt_max))
            stall_nxt = stall_cnt + cnt_one;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) stall_cnt <= '0;
        else        stall_cnt <= stall_nxt;
    end

endmodule

// File: tb/tb_li_rx_join.sv
// ---------------------------------------------------------------------------
// tb_li_rx_join
// Directed bench for li_rx_join. Two instances share clock and reset:
//   u_dut8 : width=8, depth=2, cnt_w=3
//   u_dut0 : width=0, depth=2, cnt_w=3
// Inputs change 1 time unit after a rising edge; outputs are sampled one
// further unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_li_rx_join;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    li_rx_join_if #(.width(8), .cnt_w(3)) b8 ();
    li_rx_join_if #(.width(0), .cnt_w(3)) b0 ();

    li_rx_join #(.width(8), .depth(2), .cnt_w(3)) u_dut8 (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (b8)
    );

    li_rx_join #(.width(0), .depth(2), .cnt_w(3)) u_dut0 (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (b0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int          rx_cnt;
    logic [7:0]  exp_v;
    logic [31:0] exp_stall;

    initial begin
        b8.IN_WRITE = '0; b8.IN_WRITE_VALID = 1'b0;
        b8.IN_EN_WRITE = 1'b0; b8.IN_EN_WRITE_VALID = 1'b0; b8.FIRE = 1'b0;
        b0.IN_WRITE = '0; b0.IN_WRITE_VALID = 1'b0;
        b0.IN_EN_WRITE = 1'b0; b0.IN_EN_WRITE_VALID = 1'b0; b0.FIRE = 1'b0;
        RST_N = 1'b0;

        // ---- reset: two cycles low, release with VALIDs low ----
        tick();
        tick();
        RST_N = 1'b1;
        #1;
        check("rst_ready",    b8.OUT_READY, 0);
        check("rst_wcons",    b8.IN_WRITE_CONSUMED, 1);
        check("rst_encons",   b8.IN_EN_WRITE_CONSUMED, 1);
        check("rst_stall",    b8.STALL_CNT, 0);
        check("rst_ready_w0", b0.OUT_READY, 0);
        check("rst_wcons_w0", b0.IN_WRITE_CONSUMED, 1);
        tick();

        // ---- skew: data in cycle 1, en in cycle 3, FIRE in cycle 5 ----
        b8.IN_WRITE = 8'h5A; b8.IN_WRITE_VALID = 1'b1;
        #1;
        check("skew_c1_wcons", b8.IN_WRITE_CONSUMED, 1);
        check("skew_c1_ready", b8.OUT_READY, 0);
        tick();
        b8.IN_WRITE_VALID = 1'b0;
        #1;
        check("skew_c2_ready", b8.OUT_READY, 0);
        tick();
        b8.IN_EN_WRITE = 1'b1; b8.IN_EN_WRITE_VALID = 1'b1;
        #1;
        check("skew_c3_ready", b8.OUT_READY, 0);
        tick();
        b8.IN_EN_WRITE_VALID = 1'b0;
        #1;
        check("skew_c4_ready", b8.OUT_READY, 1);
        check("skew_c4_read",  b8.OUT_READ, 8'h5A);
        check("skew_c4_en",    b8.OUT_EN, 1);
        tick();
        b8.FIRE = 1'b1;
        #1;
        check("skew_c5_ready", b8.OUT_READY, 1);
        tick();
        b8.FIRE = 1'b0;
        #1;
        check("skew_after_ready", b8.OUT_READY, 0);
        check("skew_after_stall", b8.STALL_CNT, 0);

        // ---- back-pressure: three data tokens, no en, no FIRE ----
        b8.IN_WRITE = 8'h01; b8.IN_WRITE_VALID = 1'b1;
        #1;
        check("bp_d1_wcons", b8.IN_WRITE_CONSUMED, 1);
        tick();
        b8.IN_WRITE = 8'h02;
        #1;
        check("bp_d2_wcons", b8.IN_WRITE_CONSUMED, 1);
        tick();
        b8.IN_WRITE = 8'h03;
        #1;
        check("bp_d3_wcons", b8.IN_WRITE_CONSUMED, 0);
        tick();
        #1;
        check("bp_d3_held",  b8.IN_WRITE_CONSUMED, 0);
        check("bp_d3_ready", b8.OUT_READY, 0);
        tick();
        // en 1, FIRE: pair not yet ready, so this FIRE is a stall
        b8.IN_EN_WRITE = 1'b1; b8.IN_EN_WRITE_VALID = 1'b1; b8.FIRE = 1'b1;
        #1;
        check("bp_b1_wcons",  b8.IN_WRITE_CONSUMED, 0);
        check("bp_b1_encons", b8.IN_EN_WRITE_CONSUMED, 1);
        check("bp_b1_ready",  b8.OUT_READY, 0);
        tick();
        // full data buffer: dequeue this edge, 0x03 still refused this cycle
        b8.IN_EN_WRITE = 1'b0;
        #1;
        check("bp_b2_ready", b8.OUT_READY, 1);
        check("bp_b2_read",  b8.OUT_READ, 8'h01);
        check("bp_b2_en",    b8.OUT_EN, 1);
        check("bp_b2_wcons", b8.IN_WRITE_CONSUMED, 0);
        tick();
        b8.IN_EN_WRITE = 1'b1;
        #1;
        check("bp_b3_wcons", b8.IN_WRITE_CONSUMED, 1);
        check("bp_b3_read",  b8.OUT_READ, 8'h02);
        check("bp_b3_en",    b8.OUT_EN, 0);
        tick();
        b8.IN_WRITE_VALID = 1'b0; b8.IN_EN_WRITE_VALID = 1'b0;
        #1;
        check("bp_b4_ready", b8.OUT_READY, 1);
        check("bp_b4_read",  b8.OUT_READ, 8'h03);
        check("bp_b4_en",    b8.OUT_EN, 1);
        tick();
        b8.FIRE = 1'b0;
        #1;
        check("bp_b5_ready", b8.OUT_READY, 0);
        check("bp_b5_stall", b8.STALL_CNT, 1);
        tick();

        // ---- streaming: 100 tokens, FIRE follows OUT_READY ----
        rx_cnt = 0;
        exp_v  = 8'h10;
        for (int i = 0; i <= 100; i++) begin
            b8.IN_WRITE          = 8'h10 + 8'(i);
            b8.IN_WRITE_VALID    = (i < 100);
            b8.IN_EN_WRITE       = ((i % 2) == 1);
            b8.IN_EN_WRITE_VALID = (i < 100);
            #1;
            b8.FIRE = b8.OUT_READY;
            #1;
            check("stream_wcons",  b8.IN_WRITE_CONSUMED, 1);
            check("stream_encons", b8.IN_EN_WRITE_CONSUMED, 1);
            check("stream_ready",  b8.OUT_READY, (i > 0) ? 1 : 0);
            if (b8.OUT_READY) begin
                check("stream_read", b8.OUT_READ, exp_v);
                check("stream_en",   b8.OUT_EN, exp_v[0]);
                exp_v++;
                rx_cnt++;
            end
            tick();
        end
        b8.FIRE = 1'b0;
        #1;
        check("stream_count",   rx_cnt, 100);
        check("stream_drained", b8.OUT_READY, 0);
        check("stream_stall",   b8.STALL_CNT, 1);
        tick();

        // ---- mid-run reset with 2 data and 1 en token buffered ----
        b8.IN_WRITE = 8'hAA; b8.IN_WRITE_VALID = 1'b1;
        b8.IN_EN_WRITE = 1'b1; b8.IN_EN_WRITE_VALID = 1'b1;
        tick();
        b8.IN_WRITE = 8'hBB; b8.IN_EN_WRITE_VALID = 1'b0;
        tick();
        b8.IN_WRITE_VALID = 1'b0;
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        b8.IN_WRITE = 8'hCC; b8.IN_WRITE_VALID = 1'b1;
        b8.IN_EN_WRITE = 1'b0; b8.IN_EN_WRITE_VALID = 1'b1;
        #1;
        check("mrst_ready",  b8.OUT_READY, 0);
        check("mrst_stall",  b8.STALL_CNT, 0);
        check("mrst_wcons",  b8.IN_WRITE_CONSUMED, 1);
        check("mrst_encons", b8.IN_EN_WRITE_CONSUMED, 1);
        tick();
        b8.IN_WRITE_VALID = 1'b0; b8.IN_EN_WRITE_VALID = 1'b0;
        #1;
        check("mrst_new_ready", b8.OUT_READY, 1);
        check("mrst_new_read",  b8.OUT_READ, 8'hCC);
        check("mrst_new_en",    b8.OUT_EN, 0);
        b8.FIRE = 1'b1;
        tick();
        b8.FIRE = 1'b0;
        #1;
        check("mrst_drained", b8.OUT_READY, 0);
        tick();

        // ---- stall counter saturation (cnt_w=3) ----
        b8.FIRE = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            #1;
            exp_stall = (k > 7) ? 32'd7 : 32'(k);
            check("stall_cnt", b8.STALL_CNT, exp_stall);
            check("stall_ready", b8.OUT_READY, 0);
        end
        b8.FIRE = 1'b0;
        tick();

        // ---- width=0: en tokens alone form pairs ----
        b0.IN_WRITE = 1'b1; b0.IN_WRITE_VALID = 1'b1;
        b0.IN_EN_WRITE = 1'b1; b0.IN_EN_WRITE_VALID = 1'b1;
        #1;
        check("w0_c1_wcons", b0.IN_WRITE_CONSUMED, 1);
        check("w0_c1_ready", b0.OUT_READY, 0);
        tick();
        b0.IN_EN_WRITE = 1'b0;
        #1;
        check("w0_c2_ready", b0.OUT_READY, 1);
        check("w0_c2_en",    b0.OUT_EN, 1);
        check("w0_c2_read",  b0.OUT_READ, 0);
        check("w0_c2_wcons", b0.IN_WRITE_CONSUMED, 1);
        tick();
        // en buffer full: FIRE frees a slot, but the offer waits a cycle
        b0.IN_EN_WRITE = 1'b1; b0.FIRE = 1'b1;
        #1;
        check("w0_c3_encons", b0.IN_EN_WRITE_CONSUMED, 0);
        check("w0_c3_en",     b0.OUT_EN, 1);
        tick();
        #1;
        check("w0_c4_encons", b0.IN_EN_WRITE_CONSUMED, 1);
        check("w0_c4_en",     b0.OUT_EN, 0);
        tick();
        b0.IN_EN_WRITE_VALID = 1'b0; b0.FIRE = 1'b0; b0.IN_WRITE_VALID = 1'b0;
        #1;
        check("w0_c5_ready", b0.OUT_READY, 1);
        check("w0_c5_en",    b0.OUT_EN, 1);
        check("w0_c5_wcons", b0.IN_WRITE_CONSUMED, 1);
        check("w0_stall",    b0.STALL_CNT, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/li_rx_join.md
Name: li_rx_join

Overview:
- Receiving end of the latency-insensitive VALID/CONSUMED token protocol used by the multi-cycle primitives.
- Accepts tokens on two independent input channels: a data channel (WRITE) and an enable channel (EN_WRITE).
- Buffers each channel separately and joins them into one token pair.
- Presents the pair to a single-cycle ("Normal") consumer, which takes it by pulsing FIRE. Also counts FIRE attempts that stall.

Parameters:
- width, 1: data token width; 0 means the data channel is absent.
- depth, 2: per-channel buffer entries; power of 2, >= 2.
- cnt_w, 16: width of the stall counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  reset, synchronous, active-low.
- IN_WRITE  in  max(width,1)  data token.
- IN_WRITE_VALID  in  1  data token present.
- IN_WRITE_CONSUMED  out  1  data token taken this cycle.
- IN_EN_WRITE  in  1  enable token.
- IN_EN_WRITE_VALID  in  1  enable token present.
- IN_EN_WRITE_CONSUMED  out  1  enable token taken this cycle.
- OUT_READ  out  max(width,1)  head data token; meaningful only when OUT_READY=1.
- OUT_EN  out  1  head enable token; meaningful only when OUT_READY=1.
- OUT_READY  out  1  a joined pair is available.
- FIRE  in  1  Normal-side consume strobe.
- STALL_CNT  out  cnt_w  saturating count of FIRE pulses seen while OUT_READY=0.

Behaviour:
- Reset and initial state (initial block and RST_N=0 at a posedge give the same result):
  - both buffers empty and pointers at 0; OUT_READY=0; STALL_CNT=0.
  - OUT_READ and OUT_EN read as don't-care, driven from the buffer heads.
- Handshake per channel X:
  - IN_X_CONSUMED = IN_X_VALID ? !full_X : 1.
  - Enqueue at the edge when IN_X_VALID && !full_X.
  - A producer holds its token stable while VALID && !CONSUMED.
  - CONSUMED depends only on registered occupancy. There is no combinational path from FIRE or from the other channel.
  - When full, a same-cycle FIRE does not allow a same-cycle enqueue; CONSUMED rises the following cycle.
- Join: OUT_READY = !empty_WRITE && !empty_EN (combinational from registers).
  - Dequeue both heads at the edge when FIRE && OUT_READY.
- Latency: a pair whose last token is enqueued at edge t shows OUT_READY=1 immediately after edge t. There is no bypass from input to output in the same cycle.
- Simultaneous enqueue and dequeue on a non-full channel: both happen and occupancy is unchanged.
- Wrap-around:
  - pointers are log2(depth) bits and wrap naturally.
  - occupancy counter is log2(depth)+1 bits.
  - full = (count == depth).
- Channel skew: the channels fill independently. One channel may hold up to depth tokens while the other is empty. Pairing is strictly in arrival order per channel (FIFO).
- FIRE while OUT_READY=0:
  - no dequeue.
  - STALL_CNT increments by 1, saturating at 2^cnt_w-1.
  - the count is never cleared except by reset.
- width==0:
  - data buffer is not instantiated.
  - IN_WRITE_CONSUMED=1 at all times; IN_WRITE and IN_WRITE_VALID are ignored.
  - empty_WRITE is treated as 0, so OUT_READY = !empty_EN; OUT_READ=0.
- Reset mid-operation: all buffered tokens are discarded at the reset edge. Producers observe CONSUMED=1 (when VALID=1) from the first cycle after reset release.

Decomposition:
- Sub-module li_rx_fifo(width, depth): sync FIFO with registered count, full/empty flags, and head output.
  - Instantiated once for the data channel (generate-guarded on width!=0) and once for the enable channel (width 1).
- Shared package li_pkg: none required.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles, then release with VALIDs low -> OUT_READY=0, both CONSUMED=1, STALL_CNT=0.
- Skew (width=8): data 0x5A valid in cycle 1, en=1 valid in cycle 3, FIRE in cycle 5.
  - OUT_READY=0 in cycles 2-3 and 1 from cycle 4; OUT_READ=0x5A, OUT_EN=1.
  - After the cycle-5 edge, OUT_READY=0.
- Back-pressure (depth=2): offer data 0x01, 0x02, 0x03 back-to-back with no en tokens and FIRE=0.
  - 0x01 and 0x02 consumed; 0x03 sees CONSUMED=0 and is held.
  - Then supply en 1,0,1 and FIRE each cycle -> pairs delivered in order (0x01,1), (0x02,0), (0x03,1); 0x03 is consumed one cycle after the first dequeue.
- Streaming: both channels VALID every cycle with an incrementing value, FIRE tied to OUT_READY.
  - Both CONSUMED stay 1 throughout; one pair per cycle after the initial 1-cycle latency; no value lost or duplicated over 100 tokens.
- Stall counter (cnt_w=3): FIRE=1 with OUT_READY=0 for 9 cycles -> STALL_CNT reads 1..7, then stays at 7.
- Mid-run reset and width=0:
  - Reset with 2 data tokens and 1 en token buffered -> OUT_READY=0 after the reset edge, and old tokens are never delivered.
  - With width=0: en tokens alone produce OUT_READY, and IN_WRITE_CONSUMED stays 1.
